// File: rtl/alu_pkg.sv
// rtl/alu_pkg.sv - shared funct codes, FSM encoding and flag indices for alu_seq
package alu_pkg;

    localparam logic [5:0] FN_ADD = 6'b100000;
    localparam logic [5:0] FN_SUB = 6'b100010;
    localparam logic [5:0] FN_AND = 6'b100100;
    localparam logic [5:0] FN_OR  = 6'b100101;
    localparam logic [5:0] FN_NOR = 6'b100111;
    localparam logic [5:0] FN_SLT = 6'b101010;
    localparam logic [5:0] FN_MUL = 6'b011000;
    localparam logic [5:0] FN_DIV = 6'b011010;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_FIX  = 2'd2
    } state_t;

    localparam int FL_ABOVE    = 0;
    localparam int FL_EQUALS   = 1;
    localparam int FL_OVERFLOW = 2;
    localparam int FL_DIV_ZERO = 3;
    localparam int FL_ILLEGAL  = 4;
    localparam int NFLAGS      = 5;

endpackage

// File: rtl/alu_muldiv_iter.sv
// rtl/alu_muldiv_iter.sv - unsigned iterative shift-add multiplier / restoring divider
module alu_muldiv_iter #(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             load,
    input  logic             step,
    input  logic             div_mode,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             last,
    output logic [WIDTH-1:0] hi,
    output logic [WIDTH-1:0] lo
);

    localparam int CW = $clog2(WIDTH);

    logic [WIDTH-1:0] acc_q;
    logic [WIDTH-1:0] shr_q;
    logic [WIDTH-1:0] b_q;
    logic [CW-1:0]    cnt_q;
    logic             div_q;

    logic [WIDTH:0] sum;
    logic [WIDTH:0] shifted;
    logic [WIDTH:0] diff;

    // acc:shr is the double-width product (MUL) or remainder:quotient (DIV)
    always_comb begin
        sum     = {1'b0, acc_q} + (shr_q[0] ? {1'b0, b_q} : '0);
        shifted = {acc_q, shr_q[WIDTH-1]};
        diff    = shifted - {1'b0, b_q};
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            acc_q <= '0;
            shr_q <= '0;
            b_q   <= '0;
            cnt_q <= '0;
            div_q <= 1'b0;
        end else if (load) begin
            acc_q <= '0;
            shr_q <= a;
            b_q   <= b;
            cnt_q <= CW'(WIDTH - 1);
            div_q <= div_mode;
        end else if (step) begin
            if (div_q) begin
                // borrow out of the (WIDTH+1)-bit trial subtract means restore
                if (!diff[WIDTH]) begin
                    acc_q <= diff[WIDTH-1:0];
                    shr_q <= {shr_q[WIDTH-2:0], 1'b1};
                end else begin
                    acc_q <= shifted[WIDTH-1:0];
                    shr_q <= {shr_q[WIDTH-2:0], 1'b0};
                end
            end else begin
                acc_q <= sum[WIDTH:1];
                shr_q <= {sum[0], shr_q[WIDTH-1:1]};
            end
            if (cnt_q != '0) begin
                cnt_q <= cnt_q - CW'(1);
            end
        end
    end

    assign last = (cnt_q == '0);
    assign hi   = acc_q;
    assign lo   = shr_q;

endmodule

// File: rtl/alu_seq.sv
// rtl/alu_seq.sv - multi-cycle MIPS-funct ALU with iterative signed MUL/DIV and status flags
module alu_seq
    import alu_pkg::*;
#(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [5:0]       func,
    input  logic [WIDTH-1:0] op1,
    input  logic [WIDTH-1:0] op2,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] result,
    output logic [WIDTH-1:0] result_hi,
    output logic             above,
    output logic             equals,
    output logic             overflow,
    output logic             div_zero,
    output logic             illegal
);

    localparam logic [WIDTH-1:0] MIN_VAL = {1'b1, {(WIDTH-1){1'b0}}};

    state_t state_q, state_d;

    logic [WIDTH-1:0]  res_q, res_d;
    logic [WIDTH-1:0]  hi_q, hi_d;
    logic [NFLAGS-1:0] flags_q, flags_d;
    logic              done_q;
    logic              out_we;
    logic              eng_load, eng_step, eng_last;
    logic [WIDTH-1:0]  eng_hi, eng_lo;

    logic div_q, neg_q, neg1_q, dovf_q;

    logic [WIDTH-1:0]   sum, dif, abs1, abs2, quot, rem;
    logic [2*WIDTH-1:0] prod_mag, prod_s;
    logic               lt, gt, s1, s2;

    assign s1       = op1[WIDTH-1];
    assign s2       = op2[WIDTH-1];
    assign sum      = op1 + op2;
    assign dif      = op1 - op2;
    assign lt       = $signed(op1) < $signed(op2);
    assign gt       = $signed(op1) > $signed(op2);
    assign abs1     = s1 ? -op1 : op1;
    assign abs2     = s2 ? -op2 : op2;
    assign prod_mag = {eng_hi, eng_lo};
    assign prod_s   = neg_q ? -prod_mag : prod_mag;
    assign quot     = neg_q ? -eng_lo : eng_lo;
    assign rem      = neg1_q ? -eng_hi : eng_hi;

    alu_muldiv_iter #(.WIDTH(WIDTH)) u_iter (
        .clk      (clk),
        .rst_n    (rst_n),
        .load     (eng_load),
        .step     (eng_step),
        .div_mode (func == FN_DIV),
        .a        (abs1),
        .b        (abs2),
        .last     (eng_last),
        .hi       (eng_hi),
        .lo       (eng_lo)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d  = state_q;
        eng_load = 1'b0;
        eng_step = 1'b0;
        out_we   = 1'b0;
        res_d    = '0;
        hi_d     = '0;
        flags_d  = '0;
        case (state_q)
            ST_IDLE: begin
                if (start) begin
                    out_we = 1'b1;
                    case (func)
                        FN_ADD: begin
                            res_d                = sum;
                            flags_d[FL_OVERFLOW] = (s1 == s2) && (sum[WIDTH-1] != s1);
                        end
                        FN_SUB: begin
                            res_d                = dif;
                            flags_d[FL_OVERFLOW] = (s1 != s2) && (dif[WIDTH-1] != s1);
                            flags_d[FL_ABOVE]    = gt;
                            flags_d[FL_EQUALS]   = (op1 == op2);
                        end
                        FN_AND: res_d = op1 & op2;
                        FN_OR:  res_d = op1 | op2;
                        FN_NOR: res_d = ~(op1 | op2);
                        FN_SLT: begin
                            res_d             = {{(WIDTH-1){1'b0}}, lt};
                            flags_d[FL_ABOVE] = gt;
                        end
                        FN_MUL: begin
                            out_we   = 1'b0;
                            eng_load = 1'b1;
                            state_d  = ST_RUN;
                        end
                        FN_DIV: begin
                            if (op2 == '0) begin
                                hi_d                 = op1;
                                flags_d[FL_DIV_ZERO] = 1'b1;
                            end else begin
                                out_we   = 1'b0;
                                eng_load = 1'b1;
                                state_d  = ST_RUN;
                            end
                        end
                        default: flags_d[FL_ILLEGAL] = 1'b1;
                    endcase
                end
            end
            ST_RUN: begin
                eng_step = 1'b1;
                if (eng_last) begin
                    state_d = ST_FIX;
                end
            end
            ST_FIX: begin
                out_we  = 1'b1;
                state_d = ST_IDLE;
                if (div_q) begin
                    res_d                = quot;
                    hi_d                 = rem;
                    flags_d[FL_OVERFLOW] = dovf_q;
                end else begin
                    res_d                = prod_s[WIDTH-1:0];
                    hi_d                 = prod_s[2*WIDTH-1:WIDTH];
                    flags_d[FL_OVERFLOW] = (prod_s[2*WIDTH-1:WIDTH] != {WIDTH{prod_s[WIDTH-1]}});
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // operation context captured at acceptance so operands may change afterwards
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            div_q  <= 1'b0;
            neg_q  <= 1'b0;
            neg1_q <= 1'b0;
            dovf_q <= 1'b0;
        end else if (eng_load) begin
            div_q  <= (func == FN_DIV);
            neg_q  <= s1 ^ s2;
            neg1_q <= s1;
            dovf_q <= (func == FN_DIV) && (op1 == MIN_VAL) && (op2 == '1);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            res_q   <= '0;
            hi_q    <= '0;
            flags_q <= '0;
            done_q  <= 1'b0;
        end else begin
            done_q <= out_we;
            if (out_we) begin
                res_q   <= res_d;
                hi_q    <= hi_d;
                flags_q <= flags_d;
            end
        end
    end

    assign busy      = (state_q != ST_IDLE);
    assign done      = done_q;
    assign result    = res_q;
    assign result_hi = hi_q;
    assign above     = flags_q[FL_ABOVE];
    assign equals    = flags_q[FL_EQUALS];
    assign overflow  = flags_q[FL_OVERFLOW];
    assign div_zero  = flags_q[FL_DIV_ZERO];
    assign illegal   = flags_q[FL_ILLEGAL];

endmodule

// File: tb/tb_alu_seq.sv
// tb/tb_alu_seq.sv - directed self-checking bench for alu_seq at WIDTH 32 and 8
module tb_alu_seq;
    import alu_pkg::*;

    logic clk = 1'b0;
    logic rst_n;
    always #5 clk = ~clk;

    logic        start32, busy32, done32, ab32, eq32, ovf32, dz32, ill32;
    logic [5:0]  f32;
    logic [31:0] a32, b32, res32, hi32;
    logic        start8, busy8, done8, ab8, eq8, ovf8, dz8, ill8;
    logic [5:0]  f8;
    logic [7:0]  a8, b8, res8, hi8;

    alu_seq #(.WIDTH(32)) dut32 (
        .clk(clk), .rst_n(rst_n), .start(start32), .func(f32), .op1(a32), .op2(b32),
        .busy(busy32), .done(done32), .result(res32), .result_hi(hi32),
        .above(ab32), .equals(eq32), .overflow(ovf32), .div_zero(dz32), .illegal(ill32)
    );

    alu_seq #(.WIDTH(8)) dut8 (
        .clk(clk), .rst_n(rst_n), .start(start8), .func(f8), .op1(a8), .op2(b8),
        .busy(busy8), .done(done8), .result(res8), .result_hi(hi8),
        .above(ab8), .equals(eq8), .overflow(ovf8), .div_zero(dz8), .illegal(ill8)
    );

    wire [4:0] fl32 = {ill32, dz32, ovf32, eq32, ab32};
    wire [4:0] fl8  = {ill8, dz8, ovf8, eq8, ab8};

    int checks = 0;
    int errors = 0;
    int lat, bcnt;
    bit seen;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    // called at a negedge; returns at the negedge of the done cycle
    task automatic go32(input logic [5:0] f, input logic [31:0] a, input logic [31:0] b);
        f32 = f; a32 = a; b32 = b; start32 = 1'b1;
        @(negedge clk);
        start32 = 1'b0; a32 = ~a; b32 = ~b; f32 = ~f;
        lat = 1;
        bcnt = busy32 ? 1 : 0;
        while (!done32 && lat < 100) begin
            @(negedge clk);
            lat++;
            if (busy32) bcnt++;
        end
        if (!done32) chk("timeout32", 0, 1);
    endtask

    task automatic go8(input logic [5:0] f, input logic [7:0] a, input logic [7:0] b, input bit noise);
        f8 = f; a8 = a; b8 = b; start8 = 1'b1;
        @(negedge clk);
        start8 = noise;
        if (noise) begin
            f8 = FN_ADD; a8 = 8'd1; b8 = 8'd1;
        end else begin
            a8 = ~a; b8 = ~b;
        end
        lat = 1;
        bcnt = busy8 ? 1 : 0;
        while (!done8 && lat < 100) begin
            @(negedge clk);
            lat++;
            if (busy8) bcnt++;
        end
        start8 = 1'b0;
        if (!done8) chk("timeout8", 0, 1);
    endtask

    initial begin
        rst_n = 1'b0;
        start32 = 1'b0; f32 = '0; a32 = '0; b32 = '0;
        start8 = 1'b0;  f8 = '0;  a8 = '0;  b8 = '0;
        repeat (2) @(negedge clk);
        chk("rst_busy", busy32, 0);
        chk("rst_done", done32, 0);
        chk("rst_res", res32, 0);
        chk("rst_hi", hi32, 0);
        chk("rst_flags", fl32, 5'b00000);
        chk("rst_res8", res8, 0);
        rst_n = 1'b1;
        @(negedge clk);

        go32(FN_ADD, 32'h7FFF_FFFF, 32'h1);
        chk("add_lat", lat, 1);
        chk("add_res", res32, 32'h8000_0000);
        chk("add_flags", fl32, 5'b00100);

        go32(FN_SUB, 32'd5, 32'd5);
        chk("sub_eq_res", res32, 0);
        chk("sub_eq_flags", fl32, 5'b00010);

        go32(FN_SUB, 32'd7, 32'hFFFF_FFFD);
        chk("sub_gt_res", res32, 32'd10);
        chk("sub_gt_flags", fl32, 5'b00001);

        go32(FN_AND, 32'hFF00_FF00, 32'h0FF0_0FF0);
        chk("and_res", res32, 32'h0F00_0F00);
        go32(FN_OR, 32'hFF00_FF00, 32'h0FF0_0FF0);
        chk("or_res", res32, 32'hFFF0_FFF0);
        go32(FN_NOR, 32'hF0F0_0000, 32'h0000_00FF);
        chk("nor_res", res32, 32'h0F0F_FF00);
        go32(FN_SLT, 32'hFFFF_FFFF, 32'h1);
        chk("slt_res", res32, 32'd1);
        chk("slt_flags", fl32, 5'b00000);

        go32(FN_MUL, 32'hFFFF_FFFD, 32'd7);
        chk("mul_lat", lat, 34);
        chk("mul_busy_cycles", bcnt, 33);
        chk("mul_busy_at_done", busy32, 0);
        chk("mul_res", res32, 32'hFFFF_FFEB);
        chk("mul_hi", hi32, 32'hFFFF_FFFF);
        chk("mul_flags", fl32, 5'b00000);

        go32(FN_MUL, 32'h0001_0000, 32'h0001_0000);
        chk("mulov_res", res32, 0);
        chk("mulov_hi", hi32, 1);
        chk("mulov_flags", fl32, 5'b00100);

        go32(FN_DIV, 32'hFFFF_FFF9, 32'd2);
        chk("div_lat", lat, 34);
        chk("div_res", res32, 32'hFFFF_FFFD);
        chk("div_hi", hi32, 32'hFFFF_FFFF);
        chk("div_flags", fl32, 5'b00000);

        go32(FN_DIV, 32'd9, 32'd0);
        chk("div0_lat", lat, 1);
        chk("div0_res", res32, 0);
        chk("div0_hi", hi32, 9);
        chk("div0_flags", fl32, 5'b01000);

        go32(FN_DIV, 32'h8000_0000, 32'hFFFF_FFFF);
        chk("divmin_res", res32, 32'h8000_0000);
        chk("divmin_hi", hi32, 0);
        chk("divmin_flags", fl32, 5'b00100);

        go8(FN_DIV, 8'd100, 8'd7, 1'b0);
        chk("div8_lat", lat, 10);
        chk("div8_busy_cycles", bcnt, 9);
        chk("div8_res", res8, 8'd14);
        chk("div8_hi", hi8, 8'd2);

        // issued in the done cycle of the previous op
        go8(FN_MUL, 8'hFB, 8'd3, 1'b0);
        chk("b2b8_lat", lat, 10);
        chk("b2b8_res", res8, 8'hF1);
        chk("b2b8_hi", hi8, 8'hFF);

        go8(FN_MUL, 8'd5, 8'd6, 1'b1);
        chk("noise8_lat", lat, 10);
        chk("noise8_res", res8, 8'd30);
        chk("noise8_hi", hi8, 8'd0);

        go8(FN_MUL, 8'd16, 8'd16, 1'b0);
        chk("mulov8_res", res8, 8'd0);
        chk("mulov8_hi", hi8, 8'd1);
        chk("mulov8_flags", fl8, 5'b00100);

        go8(FN_DIV, 8'h9C, 8'd7, 1'b0);
        chk("divneg8_res", res8, 8'hF2);
        chk("divneg8_hi", hi8, 8'hFE);

        @(negedge clk);
        f32 = FN_MUL; a32 = 32'd3; b32 = 32'd5; start32 = 1'b1;
        @(negedge clk);
        start32 = 1'b0;
        repeat (4) @(negedge clk);
        rst_n = 1'b0;
        #1;
        chk("abort_busy", busy32, 0);
        chk("abort_done", done32, 0);
        chk("abort_res", res32, 0);
        chk("abort_hi", hi32, 0);
        chk("abort_flags", fl32, 5'b00000);
        @(negedge clk);
        rst_n = 1'b1;
        seen = 1'b0;
        repeat (45) begin
            @(negedge clk);
            if (done32) seen = 1'b1;
        end
        chk("abort_no_done", seen, 0);

        go32(6'b111111, 32'd12, 32'd34);
        chk("ill_lat", lat, 1);
        chk("ill_res", res32, 0);
        chk("ill_hi", hi32, 0);
        chk("ill_flags", fl32, 5'b10000);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
